scheduler_acc_select: RTL

Round-robin accelerator instance selector that sits directly downstream of the per-type schedule-info memory. It accepts a task request tagged with an accelerator type and reads that type's schedule word through the memory's read port. It then grants one concrete accelerator instance ID and writes the advanced rotation pointer back through the memory's write port. It also owns that write port for host configuration writes.

---
 rtl/scheduler_acc_select.sv | 138 +++++++++++++
 1 files changed

// File: rtl/scheduler_acc_select.sv
// Round-robin accelerator instance selector: reads a type's schedule word,
// grants base+offset, and writes the advanced rotation pointer back.
module scheduler_acc_select #(
   parameter int MAX_ACC_TYPES = 16,
   parameter int ACC_TYPE_BITS = $clog2(MAX_ACC_TYPES),
   parameter int ACC_ID_BITS   = 16,
   parameter int DATA_BITS     = 3 * ACC_ID_BITS
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [ACC_TYPE_BITS-1:0] req_acc_type,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [ACC_TYPE_BITS-1:0] cfg_acc_type,
   input  logic [DATA_BITS-1:0]     cfg_data,
   output logic                     grant_valid,
   input  logic                     grant_ready,
   output logic [ACC_ID_BITS-1:0]   grant_acc_id,
   output logic                     grant_err,
   output logic [ACC_TYPE_BITS-1:0] schedData_portA_addr,
   output logic                     schedData_portA_en,
   output logic [DATA_BITS-1:0]     schedData_portA_din,
   output logic [ACC_TYPE_BITS-1:0] schedData_portB_addr,
   output logic                     schedData_portB_en,
   input  logic [DATA_BITS-1:0]     schedData_portB_dout
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_CALC  = 2'd2,
      ST_GRANT = 2'd3
   } state_e;

   localparam logic [ACC_ID_BITS-1:0] ID_ZERO = {ACC_ID_BITS{1'b0}};
   localparam logic [ACC_ID_BITS-1:0] ID_ONE  = {{(ACC_ID_BITS-1){1'b0}}, 1'b1};

   state_e                   state_q, state_d;
   logic [ACC_TYPE_BITS-1:0] type_q, type_d;
   logic [ACC_ID_BITS-1:0]   grant_id_q, grant_id_d;
   logic                     grant_err_q, grant_err_d;

   logic [ACC_ID_BITS-1:0]   base_s, count_s, offset_s;
   logic [ACC_ID_BITS-1:0]   off_eff_s, off_inc_s, next_off_s, acc_id_s;
   logic                     count_zero_s;

   assign base_s   = schedData_portB_dout[ACC_ID_BITS-1:0];
   assign count_s  = schedData_portB_dout[2*ACC_ID_BITS-1:ACC_ID_BITS];
   assign offset_s = schedData_portB_dout[3*ACC_ID_BITS-1:2*ACC_ID_BITS];

   // A stale or corrupted offset restarts rotation at the base instance.
   assign off_eff_s    = (offset_s >= count_s) ? ID_ZERO : offset_s;
   assign acc_id_s     = base_s + off_eff_s;
   assign off_inc_s    = off_eff_s + ID_ONE;
   assign next_off_s   = (off_inc_s == count_s) ? ID_ZERO : off_inc_s;
   assign count_zero_s = (count_s == ID_ZERO);

   assign grant_valid  = (state_q == ST_GRANT);
   assign grant_acc_id = grant_id_q;
   assign grant_err    = grant_err_q;

   // State and grant registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         type_q      <= {ACC_TYPE_BITS{1'b0}};
         grant_id_q  <= ID_ZERO;
         grant_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         type_q      <= type_d;
         grant_id_q  <= grant_id_d;
         grant_err_q <= grant_err_d;
      end
   end

   // Next-state, handshakes and memory port drive
   always_comb begin
      state_d              = state_q;
      type_d               = type_q;
      grant_id_d           = grant_id_q;
      grant_err_d          = grant_err_q;
      req_ready            = 1'b0;
      cfg_ready            = 1'b0;
      schedData_portA_addr = {ACC_TYPE_BITS{1'b0}};
      schedData_portA_en   = 1'b0;
      schedData_portA_din  = {DATA_BITS{1'b0}};
      schedData_portB_addr = {ACC_TYPE_BITS{1'b0}};
      schedData_portB_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cfg_ready = 1'b1;
            req_ready = !cfg_valid;
            if (cfg_valid) begin
               schedData_portA_en   = 1'b1;
               schedData_portA_addr = cfg_acc_type;
               schedData_portA_din  = cfg_data;
            end else if (req_valid) begin
               type_d  = req_acc_type;
               state_d = ST_READ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            schedData_portB_en   = 1'b1;
            schedData_portB_addr = type_q;
            state_d              = ST_CALC;
         end
         ST_CALC: begin
            if (count_zero_s) begin
               grant_id_d  = ID_ZERO;
               grant_err_d = 1'b1;
            end else begin
               grant_id_d           = acc_id_s;
               grant_err_d          = 1'b0;
               schedData_portA_en   = 1'b1;
               schedData_portA_addr = type_q;
               schedData_portA_din  = {next_off_s, count_s, base_s};
            end
            state_d = ST_GRANT;
         end
         ST_GRANT: begin
            if (grant_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_GRANT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule
